// File: rtl/sr_drv_pkg.sv
// Shared types and widths for the set/reset flip-flop driver.
package sr_drv_pkg;

  localparam int PULSE_CNT_W = 16;
  localparam int TMR_W       = 4;

  localparam logic [PULSE_CNT_W-1:0] PULSE_CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [PULSE_CNT_W-1:0] sat_inc(input logic [PULSE_CNT_W-1:0] v);
    return (v == PULSE_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// A load of N-1 therefore gives exactly N cycles with the owning state active.
module sr_drv_timer
  import sr_drv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sr_ff_driver.sv
// Request-to-pulse driver for one sr_ff: PW-cycle s/r pulses, GAP idle cycles, redundant requests dropped.
// Optional readback check of the flop's Q is enabled with SR_DRV_READBACK_EN.
module sr_ff_driver
  import sr_drv_pkg::*;
#(
  parameter int PW  = 2,
  parameter int GAP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic                   req_level,
  output logic                   req_ready,
  output logic                   s,
  output logic                   r,
  output logic                   busy,
  output logic                   q_model,
  output logic [PULSE_CNT_W-1:0] pulse_cnt
`ifdef SR_DRV_READBACK_EN
  ,
  input  logic                   q_fb,
  output logic                   mismatch
`endif
);

  localparam logic [TMR_W-1:0] PW_LD  = TMR_W'(PW - 1);
  localparam logic [TMR_W-1:0] GAP_LD = (GAP > 0) ? TMR_W'(GAP - 1) : '0;

  state_t                 state, state_nxt;
  logic                   lvl, lvl_nxt;
  logic                   q_nxt;
  logic [PULSE_CNT_W-1:0] cnt_nxt;
  logic                   tmr_load;
  logic [TMR_W-1:0]       tmr_val;
  logic                   tmr_done;

  sr_drv_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_nxt = state;
    lvl_nxt   = lvl;
    q_nxt     = q_model;
    cnt_nxt   = pulse_cnt;
    tmr_load  = 1'b0;
    tmr_val   = PW_LD;
    case (state)
      ST_IDLE: begin
        // A request that matches the current level completes here with no pulse.
        if (req_valid && (req_level != q_model)) begin
          state_nxt = ST_PULSE;
          lvl_nxt   = req_level;
          tmr_load  = 1'b1;
          tmr_val   = PW_LD;
        end
      end
      ST_PULSE: begin
        if (tmr_done) begin
          q_nxt   = lvl;
          cnt_nxt = sat_inc(pulse_cnt);
          if (GAP > 0) begin
            state_nxt = ST_GAP;
            tmr_load  = 1'b1;
            tmr_val   = GAP_LD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lvl       <= 1'b0;
      s         <= 1'b0;
      r         <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
      q_model   <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      state     <= state_nxt;
      lvl       <= lvl_nxt;
      s         <= (state_nxt == ST_PULSE) &  lvl_nxt;
      r         <= (state_nxt == ST_PULSE) & ~lvl_nxt;
      busy      <= (state_nxt != ST_IDLE);
      req_ready <= (state_nxt == ST_IDLE);
      q_model   <= q_nxt;
      pulse_cnt <= cnt_nxt;
    end
  end

`ifdef SR_DRV_READBACK_EN
  logic fb_diff, fb_diff_q;

  // Only compared in IDLE so flop propagation during PULSE/GAP is never flagged.
  assign fb_diff = (state == ST_IDLE) && (q_fb != q_model);

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_diff_q <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      fb_diff_q <= fb_diff;
      if (fb_diff && fb_diff_q) begin
        mismatch <= 1'b1;
      end
    end
  end
`endif

endmodule
